i2c_target_regs: RTL and testbench

I2C target (responder) exposing a small byte-wide register file to an external or on-board I2C controller; it is the far end of the `i2c0` open-drain controller port on the synthesizer SoC. It supports writes with auto-increment, current-pointer reads and repeated-START reads. The register contents are presented as a flat bus to synthesizer fabric, for example voice and patch configuration. It is used on-chip and as the target in bus-level simulation of the SoC's I2C controller.

---
 rtl/i2c_target_regs.sv | 99 +++++++++
 tb/tb_i2c_target_regs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing NUM_REGS byte registers with write auto-increment and pointer reads
// Line inputs are resynchronised to clk_clk; all bus events come from edges of the synced copies.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         NUM_REGS    = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  i2c_scl_in,
  input  logic                  i2c_sda_in,
  output logic                  i2c_scl_oe,
  output logic                  i2c_sda_oe,
  output logic [NUM_REGS*8-1:0] regs_q,
  output logic                  wr_stb,
  output logic [7:0]            wr_addr,
  output logic                  busy
);
  localparam int PW = $clog2(NUM_REGS);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT} state_t;
  state_t state, state_d;
  logic scl_s1, scl_s, scl_d, sda_s1, sda_s, sda_d;
  logic [7:0] shreg, rd_byte;
  logic [3:0] cnt;
  logic [PW-1:0] ptr, ptr_nx;
  logic nack, start, stop, re, fe, done, match, ptr_ok;
  logic shifting, ld, rd_shift, wr_en, ptr_ld, ptr_inc, sda_oe_d;
  assign start = scl_s & sda_d & ~sda_s;
  assign stop = scl_s & ~sda_d & sda_s;
  assign re = scl_s & ~scl_d & ~start & ~stop;
  assign fe = ~scl_s & scl_d & ~start & ~stop;
  assign done = fe && cnt == 4'd8;
  assign match = shreg[7:1] == TARGET_ADDR;
  assign ptr_ok = {24'd0, shreg} < 32'(NUM_REGS);
  assign rd_byte = regs_q[{ptr, 3'b000} +: 8];
  assign ptr_nx = (32'(ptr) == NUM_REGS - 1) ? '0 : ptr + 1'b1;
  assign i2c_scl_oe = 1'b0;
  // Idle-high reset values keep the synchronisers from inventing a START after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) {scl_s1, scl_s, scl_d, sda_s1, sda_s, sda_d} <= '1;
    else {scl_s1, scl_s, scl_d, sda_s1, sda_s, sda_d} <= {i2c_scl_in, scl_s1, scl_s, i2c_sda_in, sda_s1, sda_s};
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      ADDR:               if (done) state_d = match ? ADDR_ACK : WAIT;
      ADDR_ACK:           if (fe) state_d = shreg[0] ? RDATA : PTR;
      PTR:                if (done) state_d = ptr_ok ? PTR_ACK : WAIT;
      PTR_ACK, WDATA_ACK: if (fe) state_d = WDATA;
      WDATA:              if (done) state_d = WDATA_ACK;
      RDATA:              if (done) state_d = RDATA_ACK;
      RDATA_ACK:          if (fe) state_d = nack ? WAIT : RDATA;
      default:            ;
    endcase
    if (start) state_d = ADDR;
    if (stop) state_d = IDLE;
  end
  // The read pointer advances at the end of every transmitted byte, so a NACKed byte still counts.
  always_comb begin
    shifting = state inside {ADDR, PTR, WDATA};
    ld = fe && ((state == ADDR_ACK && shreg[0]) || (state == RDATA_ACK && !nack));
    rd_shift = fe && state == RDATA && cnt != 4'd8;
    wr_en = done && state == WDATA;
    ptr_ld = done && state == PTR && ptr_ok;
    ptr_inc = done && (state == WDATA || state == RDATA);
    sda_oe_d = (start | stop) ? 1'b0 :
               !fe ? i2c_sda_oe :
               (state_d inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) ? 1'b1 :
               (state_d == RDATA) ? ~(ld ? rd_byte[7] : shreg[6]) : 1'b0;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      i2c_sda_oe <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      ptr <= '0;
      nack <= 1'b0;
      regs_q <= '0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      busy <= 1'b0;
    end else begin
      i2c_sda_oe <= sda_oe_d;
      wr_stb <= wr_en;
      cnt <= (start || stop || (fe && state_d != state)) ? '0 : (re && (shifting || state == RDATA)) ? cnt + 4'd1 : cnt;
      if (re && shifting) shreg <= {shreg[6:0], sda_s};
      else if (ld) shreg <= rd_byte;
      else if (rd_shift) shreg <= {shreg[6:0], 1'b0};
      if (re && state == RDATA_ACK) nack <= sda_s;
      if (ptr_ld) ptr <= shreg[PW-1:0];
      else if (ptr_inc) ptr <= ptr_nx;
      if (wr_en) begin
        regs_q[{ptr, 3'b000} +: 8] <= shreg;
        wr_addr <= 8'(ptr);
      end
      busy <= stop ? 1'b0 : (done && state == ADDR) ? match : busy;
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C controller driving directed transactions against i2c_target_regs
module tb_i2c_target_regs;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, scl_drv = 1'b1, sda_drv = 1'b1;
  logic scl_line, sda_line, scl_oe, sda_oe, wr_stb, busy, a;
  logic [127:0] regs_q;
  logic [7:0] wr_addr, rb;
  logic [7:0] exp_regs [16];
  logic [7:0] stb_q [$];
  int n_cmp = 0, n_err = 0;

  i2c_target_regs #(.TARGET_ADDR(7'h2A), .NUM_REGS(16)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .i2c_scl_in(scl_line), .i2c_sda_in(sda_line),
    .i2c_scl_oe(scl_oe), .i2c_sda_oe(sda_oe), .regs_q(regs_q), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;
  assign scl_line = scl_drv & ~scl_oe;
  assign sda_line = sda_drv & ~sda_oe;
  always @(negedge clk) if (wr_stb) stb_q.push_back(wr_addr);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*i +: 8] = exp_regs[i];
    return p;
  endfunction

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start();
    sda_drv = 1'b1; q(); scl_drv = 1'b1; q(); sda_drv = 1'b0; q(); scl_drv = 1'b0; q();
  endtask
  task automatic i2c_stop();
    sda_drv = 1'b0; q(); scl_drv = 1'b1; q(); sda_drv = 1'b1; q();
  endtask
  task automatic put_bit(input logic b);
    sda_drv = b; q(); scl_drv = 1'b1; q(); q(); scl_drv = 1'b0; q();
  endtask
  task automatic get_bit(output logic b);
    sda_drv = 1'b1; q(); scl_drv = 1'b1; q(); b = sda_line; q(); scl_drv = 1'b0; q();
  endtask
  task automatic send(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask
  task automatic recv(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 128'(sda_oe), 128'(1'b0));
    chk("rst_scl_oe", 128'(scl_oe), 128'(1'b0));
    chk("rst_regs", regs_q, 128'h0);
    chk("rst_wr_stb", 128'(wr_stb), 128'(1'b0));
    chk("rst_wr_addr", 128'(wr_addr), 128'h0);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    rst_n = 1'b1;
    q();
    // write two bytes from pointer 3
    i2c_start();
    send(8'h54, a); chk("t1_addr_ack", 128'(a), 128'(1'b0));
    chk("t1_busy_hi", 128'(busy), 128'(1'b1));
    send(8'h03, a); chk("t1_ptr_ack", 128'(a), 128'(1'b0));
    send(8'h5A, a); chk("t1_d0_ack", 128'(a), 128'(1'b0));
    send(8'hC3, a); chk("t1_d1_ack", 128'(a), 128'(1'b0));
    chk("t1_scl_oe", 128'(scl_oe), 128'(1'b0));
    i2c_stop();
    exp_regs[3] = 8'h5A; exp_regs[4] = 8'hC3;
    chk("t1_busy_lo", 128'(busy), 128'(1'b0));
    chk("t1_stb_n", 128'(stb_q.size()), 128'd2);
    if (stb_q.size() == 2) begin
      chk("t1_stb_a0", 128'(stb_q[0]), 128'h03);
      chk("t1_stb_a1", 128'(stb_q[1]), 128'h04);
    end
    chk("t1_wr_addr", 128'(wr_addr), 128'h04);
    chk("t1_regs", regs_q, model());
    i2c_start(); send(8'h54, a); send(8'h05, a); send(8'h77, a); i2c_stop();
    exp_regs[5] = 8'h77;
    stb_q.delete();
    // pointer set, repeated START, two-byte read
    i2c_start(); send(8'h54, a); send(8'h03, a);
    i2c_start();
    send(8'h55, a); chk("t2_rd_ack", 128'(a), 128'(1'b0));
    chk("t2_busy_rs", 128'(busy), 128'(1'b1));
    recv(1'b0, rb); chk("t2_rd0", 128'(rb), 128'h5A);
    recv(1'b1, rb); chk("t2_rd1", 128'(rb), 128'hC3);
    i2c_stop();
    i2c_start(); send(8'h55, a); recv(1'b1, rb); i2c_stop();
    chk("t2_cur_ptr5", 128'(rb), 128'h77);
    chk("t2_no_stb", 128'(stb_q.size()), 128'd0);
    // wrong address and general call are ignored
    i2c_start();
    send(8'h56, a); chk("t3_addr_nack", 128'(a), 128'(1'b1));
    chk("t3_busy", 128'(busy), 128'(1'b0));
    send(8'h00, a); chk("t3_b1_nack", 128'(a), 128'(1'b1));
    send(8'h99, a); chk("t3_b2_nack", 128'(a), 128'(1'b1));
    i2c_stop();
    i2c_start(); send(8'h00, a); chk("t3_gcall_nack", 128'(a), 128'(1'b1)); i2c_stop();
    chk("t3_no_stb", 128'(stb_q.size()), 128'd0);
    chk("t3_regs", regs_q, model());
    // out-of-range pointer keeps the old pointer
    i2c_start(); send(8'h54, a); send(8'h03, a); i2c_stop();
    i2c_start(); send(8'h54, a);
    send(8'h10, a); chk("t4_ptr_nack", 128'(a), 128'(1'b1));
    send(8'hEE, a); chk("t4_data_nack", 128'(a), 128'(1'b1));
    i2c_stop();
    chk("t4_no_stb", 128'(stb_q.size()), 128'd0);
    chk("t4_regs", regs_q, model());
    i2c_start(); send(8'h55, a); recv(1'b1, rb); i2c_stop();
    chk("t4_ptr_kept", 128'(rb), 128'h5A);
    // write wraps from 15 to 0
    i2c_start(); send(8'h54, a); send(8'h0F, a);
    send(8'h11, a); send(8'h22, a); send(8'h33, a);
    chk("t5_d2_ack", 128'(a), 128'(1'b0));
    i2c_stop();
    exp_regs[15] = 8'h11; exp_regs[0] = 8'h22; exp_regs[1] = 8'h33;
    chk("t5_regs", regs_q, model());
    chk("t5_stb_n", 128'(stb_q.size()), 128'd3);
    if (stb_q.size() == 3) begin
      chk("t5_stb_a0", 128'(stb_q[0]), 128'h0F);
      chk("t5_stb_a1", 128'(stb_q[1]), 128'h00);
      chk("t5_stb_a2", 128'(stb_q[2]), 128'h01);
    end
    stb_q.delete();
    // STOP inside a data byte aborts it
    i2c_start(); send(8'h54, a); send(8'h07, a);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    chk("t6_abort_stb", 128'(stb_q.size()), 128'd0);
    chk("t6_abort_regs", regs_q, model());
    i2c_start(); send(8'h54, a); send(8'h07, a);
    send(8'h3C, a); chk("t6_next_ack", 128'(a), 128'(1'b0));
    i2c_stop();
    exp_regs[7] = 8'h3C;
    chk("t6_next_regs", regs_q, model());
    chk("t6_next_stb", 128'(stb_q.size()), 128'd1);
    // reset in the read ACK slot
    i2c_start(); send(8'h54, a); send(8'h03, a);
    i2c_start(); send(8'h55, a);
    for (int i = 7; i >= 0; i--) begin
      get_bit(a);
      rb[i] = a;
    end
    chk("t7_rd_pre", 128'(rb), 128'h5A);
    sda_drv = 1'b0; q(); scl_drv = 1'b1; q();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_sda", 128'(sda_oe), 128'(1'b0));
    chk("t7_rst_busy", 128'(busy), 128'(1'b0));
    chk("t7_rst_regs", regs_q, 128'h0);
    chk("t7_rst_wr_addr", 128'(wr_addr), 128'h0);
    q(); rst_n = 1'b1; q(); scl_drv = 1'b0; q();
    i2c_stop();
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    i2c_start();
    send(8'h54, a); chk("t7_rec_addr", 128'(a), 128'(1'b0));
    send(8'h08, a);
    send(8'hA5, a); chk("t7_rec_data", 128'(a), 128'(1'b0));
    i2c_stop();
    exp_regs[8] = 8'hA5;
    i2c_start(); send(8'h54, a); send(8'h08, a);
    i2c_start(); send(8'h55, a); recv(1'b1, rb); i2c_stop();
    chk("t7_rec_rd", 128'(rb), 128'hA5);
    chk("t7_rec_regs", regs_q, model());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
